// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the lab3 stopwatch controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ADJ   = 2'd3
   } state_t;

   localparam int MAX_VAL_DEF = 59;
   localparam int ADJ_DIV_DEF = 25;
   localparam int FIELD_W_DEF = 6;

endpackage

// File: rtl/stopwatch_ctrl_tick_edge.sv
// Registers one divided level clock and emits a registered single-cycle pulse
// on each of its rising edges.
module tick_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic level_in,
   output logic level_q,
   output logic tick_q
);

   logic tick_d;

   always_comb begin
      tick_d = level_in & ~level_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         level_q <= level_in;
         tick_q  <= tick_d;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: clear/run/pause/adjust FSM and MM:SS registers.
// Optional lap freeze of the displayed time is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MAX_VAL = MAX_VAL_DEF,
   parameter int ADJ_DIV = ADJ_DIV_DEF,
   parameter int FIELD_W = FIELD_W_DEF
) (
   input  logic               internal_clk,
   input  logic               rst_n,
   input  logic               unit_clock,
   input  logic               fast_clock,
   input  logic               blink_clock,
   input  logic               btn_pause,
   input  logic               btn_clear,
   input  logic               sw_adj,
   input  logic               sw_sel,
   output logic [FIELD_W-1:0] minutes,
   output logic [FIELD_W-1:0] seconds,
   output logic               running,
   output logic               blank_min,
   output logic               blank_sec
);

   localparam int CNT_W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;

   state_t             state_q, state_d;
   logic [FIELD_W-1:0] min_q, min_d, sec_q, sec_d;
   logic [CNT_W-1:0]   adj_cnt_q, adj_cnt_d;
   logic               running_q, running_d;
   logic               adj_tick;
   logic               unit_tick, fast_tick, blink_tick;
   logic               unit_lvl, fast_lvl, blink_lvl;
   logic               unused_edge;

`ifdef STOPWATCH_LAP_EN
   logic               lap_frz_q, lap_frz_d;
   logic [FIELD_W-1:0] lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
`endif

   tick_edge u_unit_edge (
      .clk      (internal_clk),
      .rst_n    (rst_n),
      .level_in (unit_clock),
      .level_q  (unit_lvl),
      .tick_q   (unit_tick)
   );

   tick_edge u_fast_edge (
      .clk      (internal_clk),
      .rst_n    (rst_n),
      .level_in (fast_clock),
      .level_q  (fast_lvl),
      .tick_q   (fast_tick)
   );

   tick_edge u_blink_edge (
      .clk      (internal_clk),
      .rst_n    (rst_n),
      .level_in (blink_clock),
      .level_q  (blink_lvl),
      .tick_q   (blink_tick)
   );

   // Only the blink level is consumed; the other edge outputs are by-products.
   assign unused_edge = unit_lvl ^ fast_lvl ^ blink_tick;

   function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] f);
      return (f == FIELD_W'(MAX_VAL)) ? '0 : f + FIELD_W'(1);
   endfunction

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      sec_d     = sec_q;
      adj_cnt_d = adj_cnt_q;
      adj_tick  = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_frz_d = lap_frz_q;
      lap_min_d = lap_min_q;
      lap_sec_d = lap_sec_q;
`endif

      // Prescaler runs only inside ADJ and sits at zero elsewhere, so entry starts clean.
      if (state_q == ST_ADJ) begin
         if (fast_tick) begin
            if (adj_cnt_q == CNT_W'(ADJ_DIV - 1)) begin
               adj_cnt_d = '0;
               adj_tick  = 1'b1;
            end else begin
               adj_cnt_d = adj_cnt_q + CNT_W'(1);
            end
         end
      end else begin
         adj_cnt_d = '0;
      end

      if (btn_clear) begin
         min_d = '0;
         sec_d = '0;
         if (state_q != ST_ADJ) state_d = ST_IDLE;
`ifdef STOPWATCH_LAP_EN
         lap_frz_d = 1'b0;
`endif
      end else if (state_q == ST_ADJ) begin
         if (!sw_adj) begin
            state_d = ST_PAUSE;
         end else if (adj_tick) begin
            if (sw_sel) min_d = wrap_inc(min_q);
            else        sec_d = wrap_inc(sec_q);
         end
      end else begin
         // A count tick in RUN lands even when the state changes in the same cycle.
         if (state_q == ST_RUN && unit_tick) begin
            sec_d = wrap_inc(sec_q);
            if (sec_q == FIELD_W'(MAX_VAL)) min_d = wrap_inc(min_q);
         end
         if (sw_adj) begin
            state_d = ST_ADJ;
`ifdef STOPWATCH_LAP_EN
            lap_frz_d = 1'b0;
`endif
         end else if (btn_pause) begin
            if (state_q == ST_RUN) begin
`ifdef STOPWATCH_LAP_EN
               lap_frz_d = ~lap_frz_q;
               lap_min_d = min_q;
               lap_sec_d = sec_q;
`else
               state_d = ST_PAUSE;
`endif
            end else begin
               state_d = ST_RUN;
            end
         end
      end

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         min_q     <= '0;
         sec_q     <= '0;
         adj_cnt_q <= '0;
         running_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_frz_q <= 1'b0;
         lap_min_q <= '0;
         lap_sec_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         adj_cnt_q <= adj_cnt_d;
         running_q <= running_d;
`ifdef STOPWATCH_LAP_EN
         lap_frz_q <= lap_frz_d;
         lap_min_q <= lap_min_d;
         lap_sec_q <= lap_sec_d;
`endif
      end
   end

`ifdef STOPWATCH_LAP_EN
   assign minutes = lap_frz_q ? lap_min_q : min_q;
   assign seconds = lap_frz_q ? lap_sec_q : sec_q;
`else
   assign minutes = min_q;
   assign seconds = sec_q;
`endif

   assign running   = running_q;
   assign blank_sec = (state_q == ST_ADJ) & ~sw_sel & ~blink_lvl;
   assign blank_min = (state_q == ST_ADJ) &  sw_sel & ~blink_lvl;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed steps plus a random phase,
// each cycle compared against a time-arithmetic reference model.
module tb_stopwatch_ctrl;

   localparam int MAX_VAL = 59;
   localparam int ADJ_DIV = 25;
   localparam int FIELD_W = 6;
   localparam int N_VAL   = MAX_VAL + 1;

   localparam int MD_IDLE  = 0;
   localparam int MD_RUN   = 1;
   localparam int MD_PAUSE = 2;
   localparam int MD_ADJ   = 3;

   logic               internal_clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               unit_clock = 1'b0, fast_clock = 1'b0, blink_clock = 1'b0;
   logic               btn_pause = 1'b0, btn_clear = 1'b0;
   logic               sw_adj = 1'b0, sw_sel = 1'b0;
   logic [FIELD_W-1:0] minutes, seconds;
   logic               running, blank_min, blank_sec;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   // Reference model state: what the stopwatch should show, in plain integers.
   int m_mode, m_min, m_sec, m_nfast, m_lap_min, m_lap_sec;
   bit m_frozen, m_u_prev, m_u_pend, m_f_prev, m_f_pend, m_blink_seen;

   stopwatch_ctrl #(.MAX_VAL(MAX_VAL), .ADJ_DIV(ADJ_DIV), .FIELD_W(FIELD_W)) dut (
      .internal_clk (internal_clk),
      .rst_n        (rst_n),
      .unit_clock   (unit_clock),
      .fast_clock   (fast_clock),
      .blink_clock  (blink_clock),
      .btn_pause    (btn_pause),
      .btn_clear    (btn_clear),
      .sw_adj       (sw_adj),
      .sw_sel       (sw_sel),
      .minutes      (minutes),
      .seconds      (seconds),
      .running      (running),
      .blank_min    (blank_min),
      .blank_sec    (blank_sec)
   );

   always #5 internal_clk = ~internal_clk;

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not reach its end, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode = MD_IDLE; m_min = 0; m_sec = 0; m_nfast = 0;
      m_frozen = 0; m_lap_min = 0; m_lap_sec = 0;
      m_u_prev = 0; m_u_pend = 0; m_f_prev = 0; m_f_pend = 0; m_blink_seen = 0;
   endfunction

   // One internal_clk edge: an input edge seen now takes effect at the next edge.
   function automatic void model_step();
      bit ut, ft, adj_fire;
      int t, pre_min, pre_sec;
      ut = m_u_pend;
      ft = m_f_pend;
      m_u_pend = unit_clock && !m_u_prev;  m_u_prev = unit_clock;
      m_f_pend = fast_clock && !m_f_prev;  m_f_prev = fast_clock;
      m_blink_seen = blink_clock;
      if (m_mode != MD_ADJ) m_nfast = 0;
      adj_fire = 0;
      if (m_mode == MD_ADJ && ft) begin
         m_nfast++;
         adj_fire = (m_nfast % ADJ_DIV == 0);
      end
      pre_min = m_min;
      pre_sec = m_sec;
      if (btn_clear) begin
         m_min = 0; m_sec = 0; m_frozen = 0;
         if (m_mode != MD_ADJ) m_mode = MD_IDLE;
      end else if (m_mode == MD_ADJ) begin
         if (!sw_adj) m_mode = MD_PAUSE;
         else if (adj_fire) begin
            if (sw_sel) m_min = (m_min + 1) % N_VAL;
            else        m_sec = (m_sec + 1) % N_VAL;
         end
      end else begin
         if (m_mode == MD_RUN && ut) begin
            t = (m_min * N_VAL + m_sec + 1) % (N_VAL * N_VAL);
            m_min = t / N_VAL;
            m_sec = t % N_VAL;
         end
         if (sw_adj) begin
            m_mode = MD_ADJ; m_frozen = 0;
         end else if (btn_pause) begin
            if (m_mode == MD_RUN) begin
`ifdef STOPWATCH_LAP_EN
               m_frozen = !m_frozen;
               m_lap_min = pre_min;
               m_lap_sec = pre_sec;
`else
               m_mode = MD_PAUSE;
`endif
            end else begin
               m_mode = MD_RUN;
            end
         end
      end
   endfunction

   task automatic compare_model();
      check("minutes",   32'(minutes),   32'(m_frozen ? m_lap_min : m_min));
      check("seconds",   32'(seconds),   32'(m_frozen ? m_lap_sec : m_sec));
      check("running",   32'(running),   32'(m_mode == MD_RUN));
      check("blank_min", 32'(blank_min), 32'(m_mode == MD_ADJ && sw_sel && !m_blink_seen));
      check("blank_sec", 32'(blank_sec), 32'(m_mode == MD_ADJ && !sw_sel && !m_blink_seen));
   endtask

   task automatic cyc();
      @(posedge internal_clk);
      model_step();
      @(negedge internal_clk);
      compare_model();
   endtask

   task automatic pulse_pause();
      btn_pause = 1'b1; cyc(); btn_pause = 1'b0;
   endtask

   task automatic pulse_clear();
      btn_clear = 1'b1; cyc(); btn_clear = 1'b0;
   endtask

   task automatic unit_edges(input int n);
      for (int i = 0; i < n; i++) begin
         unit_clock = 1'b1; cyc();
         unit_clock = 1'b0; cyc();
      end
   endtask

   task automatic fast_edges(input int n);
      for (int i = 0; i < n; i++) begin
         fast_clock = 1'b1; cyc();
         fast_clock = 1'b0; cyc();
      end
   endtask

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge internal_clk);
      check("reset_minutes",   32'(minutes),   0);
      check("reset_seconds",   32'(seconds),   0);
      check("reset_running",   32'(running),   0);
      check("reset_blank_min", 32'(blank_min), 0);
      check("reset_blank_sec", 32'(blank_sec), 0);
      rst_n = 1'b1;
      cyc();

      // Count 61 seconds from 00:00.
      pulse_pause();
      unit_clock = 1'b1; cyc();
      check("latency_1cyc_sec", 32'(seconds), 0);
      unit_clock = 1'b0; cyc();
      check("latency_2cyc_sec", 32'(seconds), 1);
      unit_edges(60);
      check("run61_minutes", 32'(minutes), 1);
      check("run61_seconds", 32'(seconds), 1);
      check("run61_running", 32'(running), 1);

      pulse_clear();
      check("clear_minutes", 32'(minutes), 0);
      check("clear_running", 32'(running), 0);

      // Adjust: seconds first, then minutes, then seconds wrap.
      sw_adj = 1'b1; sw_sel = 1'b0; cyc();
      fast_edges(50);
      check("adj50_seconds", 32'(seconds), 2);
      check("adj50_minutes", 32'(minutes), 0);
      check("adj_sel0_blank_sec", 32'(blank_sec), 1);
      sw_sel = 1'b1;
      fast_edges(59 * ADJ_DIV);
      check("adjmin_minutes", 32'(minutes), 59);
      check("adjmin_seconds", 32'(seconds), 2);
      check("blink_lo_blank_min", 32'(blank_min), 1);
      check("blink_lo_blank_sec", 32'(blank_sec), 0);
      blink_clock = 1'b1; cyc();
      check("blink_hi_blank_min", 32'(blank_min), 0);
      check("blink_hi_blank_sec", 32'(blank_sec), 0);
      blink_clock = 1'b0; cyc();
      sw_sel = 1'b0;
      fast_edges(57 * ADJ_DIV);
      check("adj_5959_seconds", 32'(seconds), 59);
      fast_edges(ADJ_DIV);
      check("adj_wrap_seconds", 32'(seconds), 0);
      check("adj_wrap_minutes", 32'(minutes), 59);
      fast_edges(59 * ADJ_DIV);
      sw_adj = 1'b0; cyc();
      check("exit_adj_blank_min", 32'(blank_min), 0);
      check("exit_adj_blank_sec", 32'(blank_sec), 0);
      check("exit_adj_running",   32'(running),   0);
      check("exit_adj_seconds",   32'(seconds),   59);

      // Full wrap 59:59 -> 00:00.
      pulse_pause();
      check("resume_running", 32'(running), 1);
      unit_edges(1);
      check("wrap_minutes", 32'(minutes), 0);
      check("wrap_seconds", 32'(seconds), 0);

      // Clear coinciding with a tick at 00:05.
      unit_edges(5);
      check("pre_clear_seconds", 32'(seconds), 5);
      unit_clock = 1'b1; cyc();
      unit_clock = 1'b0; btn_clear = 1'b1; cyc(); btn_clear = 1'b0;
      check("clear_tick_seconds", 32'(seconds), 0);
      check("clear_tick_running", 32'(running), 0);

      // Pause coinciding with a tick.
      pulse_pause();
      unit_clock = 1'b1; cyc();
      unit_clock = 1'b0; btn_pause = 1'b1; cyc(); btn_pause = 1'b0;
`ifdef STOPWATCH_LAP_EN
      check("pause_tick_lap_seconds", 32'(seconds), 0);
      check("pause_tick_lap_running", 32'(running), 1);
      pulse_pause();
      check("lap_release_seconds", 32'(seconds), 1);
`else
      check("pause_tick_seconds", 32'(seconds), 1);
      check("pause_tick_running", 32'(running), 0);
`endif

      // Random phase against the model.
      for (int i = 0; i < 400; i++) begin
         btn_pause   = ($urandom_range(0, 15) == 0);
         btn_clear   = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 39) == 0) sw_adj = ~sw_adj;
         if ($urandom_range(0, 19) == 0) sw_sel = ~sw_sel;
         unit_clock  = 1'($urandom_range(0, 1));
         fast_clock  = 1'($urandom_range(0, 1));
         blink_clock = 1'($urandom_range(0, 1));
         cyc();
      end
      btn_pause = 1'b0; btn_clear = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
      unit_clock = 1'b0; fast_clock = 1'b0; blink_clock = 1'b0;
      repeat (3) cyc();

      // Run to 03:17, then an asynchronous reset between clock edges.
      pulse_clear();
      pulse_pause();
      unit_edges(197);
      check("t0317_minutes", 32'(minutes), 3);
      check("t0317_seconds", 32'(seconds), 17);
`ifdef STOPWATCH_LAP_EN
      pulse_pause();
      unit_edges(3);
      check("lap_hold_minutes", 32'(minutes), 3);
      check("lap_hold_seconds", 32'(seconds), 17);
      check("lap_hold_running", 32'(running), 1);
      pulse_pause();
      check("lap_free_seconds", 32'(seconds), 20);
`endif
      @(posedge internal_clk);
      model_step();
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_minutes", 32'(minutes), 0);
      check("async_rst_seconds", 32'(seconds), 0);
      check("async_rst_running", 32'(running), 0);
      model_reset();
      @(negedge internal_clk);
      rst_n = 1'b1;
      repeat (2) cyc();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
